frame_strobe_sequencer: RTL and testbench
=========================================

// Module: frame_strobe_sequencer
// PURPOSE
//   Loads a tile's configuration latch frames (LHQD1 array, transparent while E=1) from a valid/ready word stream.
//   Per frame: presents one FrameBitsPerRow word on FrameData, pulses exactly one FrameStrobe bit, and holds
//   FrameData stable before and after the pulse.
//   Sits between the column frame-data feeder and the tile ConfigMem FrameData/FrameStrobe inputs.
// PARAMETERS
//   FrameBitsPerRow  32  width of s_data / FrameData
//   MaxFramesPerCol  20  width of FrameStrobe
//   NumFrames        3   frames written per load sequence (1..MaxFramesPerCol)
//   FirstFrame       0   strobe index of first frame (FirstFrame+NumFrames <= MaxFramesPerCol)
//   SETUP_CYCLES     1   cycles FrameData is stable before strobe (>=1)
//   STROBE_CYCLES    2   cycles strobe is high (>=1)
//   HOLD_CYCLES      1   cycles FrameData is stable after strobe falls (>=1)
// PORTS
//   CLK          in   1                clock
//   reset        in   1                synchronous, active-high reset
//   start        in   1                begin load sequence; sampled only in IDLE
//   abort        in   1                cancel; honoured only in LOAD
//   s_valid      in   1                frame word valid
//   s_data       in   FrameBitsPerRow  frame word, frame order FirstFrame upward
//   s_ready      out  1                word accepted when s_valid & s_ready
//   FrameData    out  FrameBitsPerRow  to ConfigMem FrameData
//   FrameStrobe  out  MaxFramesPerCol  to ConfigMem FrameStrobe, at most one bit high
//   frame_idx    out  5                frames completed in current sequence
//   busy         out  1                high in every state except IDLE
//   done         out  1                one-cycle pulse, sequence complete
//   aborted      out  1                one-cycle pulse, sequence cancelled
// BEHAVIOUR
//   - Reset: all outputs 0; state IDLE; counters 0.
//     Reset asserted mid-strobe drops FrameStrobe to 0 at the next edge.
//   - All outputs are registered or decoded from registered state; no combinational input->output path.
//   - States and transitions:
//     - IDLE: start -> LOAD, frame_idx=0.
//     - LOAD: s_ready=1. Handshake captures s_data into FrameData -> SETUP.
//       abort (priority over handshake) -> ABORT.
//     - SETUP: SETUP_CYCLES cycles -> STROBE.
//     - STROBE: FrameStrobe[FirstFrame+frame_idx]=1 for exactly STROBE_CYCLES cycles -> HOLD.
//     - HOLD: HOLD_CYCLES cycles. Then frame_idx++; if frame_idx==NumFrames -> DONE, else -> LOAD.
//     - DONE: done=1 for one cycle -> IDLE.
//     - ABORT: aborted=1 for one cycle -> IDLE.
//   - FrameData changes only on a LOAD handshake; otherwise held, including in IDLE.
//   - s_ready is 0 outside LOAD, so no back-to-back acceptance.
//   - Minimum cycles per frame = 1 + SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES.
//   - Interaction with other inputs:
//     - start while busy: ignored.
//     - abort outside LOAD: ignored.
//     - start and abort together in IDLE: start wins.
//     - s_valid stalls in LOAD indefinitely with no timeout.
//   - frame_idx stays at its final value in IDLE until the next start.
//   - Cycle counters wrap never: each counter resets on entry to its state.
// TESTING
//   - Reset then idle:
//     - FrameStrobe=0, FrameData=0, s_ready=0, busy=0 for 10 cycles.
//   - Defaults, start@c0, s_valid held high with words A,B,C:
//     - s_ready high c1, c6, c11.
//     - FrameStrobe=0x00001 c3-c4, 0x00002 c8-c9, 0x00004 c13-c14.
//     - done at c16.
//   - Same run with s_valid low 4 cycles before word B:
//     - strobe 1 delayed 4 cycles.
//     - FrameData==A throughout the stall.
//   - abort in LOAD before word B:
//     - aborted pulse next cycle; FrameStrobe never shows bit1; busy drops.
//   - reset asserted while FrameStrobe=0x00002:
//     - next edge FrameStrobe=0, FrameData=0, state IDLE.
//   - FirstFrame=17, NumFrames=3, STROBE_CYCLES=1:
//     - strobe bits 17,18,19, one cycle each.
//     - start pulsed during the sequence is ignored.

Source files
------------

// File: rtl/frame_strobe_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_strobe_sequencer_if
// Purpose  : Valid/ready word stream carrying configuration frame words from
//            the column frame-data feeder into frame_strobe_sequencer.
// Signals  : s_valid  feeder -> sequencer  word valid
//            s_data   feeder -> sequencer  frame word (FrameBitsPerRow bits)
//            s_ready  sequencer -> feeder  word accepted when valid & ready
// Modports : master (feeder side), slave (sequencer side)
// Revision : 1.0  initial release
// ============================================================================
interface frame_strobe_sequencer_if #(
  parameter int FrameBitsPerRow = 32
);
  logic                       s_valid;
  logic [FrameBitsPerRow-1:0] s_data;
  logic                       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/frame_strobe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_strobe_sequencer
// Purpose  : Loads a tile's configuration latch frames. For each frame one
//            word is accepted from the stream, presented on FrameData for a
//            setup period, strobed into one FrameStrobe row, then held.
// Ports    : CLK          clock
//            reset        synchronous active-high reset
//            start        begin a load sequence (sampled only when idle)
//            abort        cancel a sequence (honoured only while loading)
//            s_if         slave side of the frame word stream
//            FrameData    frame word to ConfigMem
//            FrameStrobe  one-hot row strobe to ConfigMem
//            frame_idx    frames completed in the current sequence
//            busy         high whenever not idle
//            done         one-cycle pulse, sequence complete
//            aborted      one-cycle pulse, sequence cancelled
// Revision : 1.0  initial release
// ============================================================================
module frame_strobe_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumFrames       = 3,
  parameter int FirstFrame      = 0,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1
) (
  input  wire logic                       CLK,
  input  wire logic                       reset,
  input  wire logic                       start,
  input  wire logic                       abort,
  frame_strobe_sequencer_if.slave         s_if,
  output logic [FrameBitsPerRow-1:0]      FrameData,
  output logic [MaxFramesPerCol-1:0]      FrameStrobe,
  output logic [4:0]                      frame_idx,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD   = 3'd1;
  localparam logic [2:0] c_SETUP  = 3'd2;
  localparam logic [2:0] c_STROBE = 3'd3;
  localparam logic [2:0] c_HOLD   = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;
  localparam logic [2:0] c_ABORT  = 3'd6;

  // Terminal counts: each phase counter starts at 0 on state entry.
  localparam logic [15:0] c_SETUP_LAST  = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] c_STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] c_HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [4:0]  c_NUM_FRAMES  = 5'(NumFrames);
  localparam logic [7:0]  c_FIRST_FRAME = 8'(FirstFrame);
  localparam logic [MaxFramesPerCol-1:0] c_ONE = MaxFramesPerCol'(1);

  logic [2:0]                 r_state;
  logic [15:0]                r_cnt;
  logic [4:0]                 r_frame_idx;
  logic [FrameBitsPerRow-1:0] r_frame_data;

  logic [4:0]                 w_idx_inc;
  logic [7:0]                 w_strobe_bit;

  assign w_idx_inc    = r_frame_idx + 5'd1;
  assign w_strobe_bit = c_FIRST_FRAME + {3'b000, r_frame_idx};

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_frame_idx  <= '0;
      r_frame_data <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state     <= c_LOAD;
            r_frame_idx <= '0;
          end
        end
        c_LOAD: begin
          // Abort takes priority over a word offered in the same cycle.
          if (abort) begin
            r_state <= c_ABORT;
          end else if (s_if.s_valid) begin
            r_frame_data <= s_if.s_data;
            r_cnt        <= '0;
            r_state      <= c_SETUP;
          end
        end
        c_SETUP: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_cnt   <= '0;
            r_state <= c_STROBE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_STROBE: begin
          if (r_cnt == c_STROBE_LAST) begin
            r_cnt   <= '0;
            r_state <= c_HOLD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_cnt       <= '0;
            r_frame_idx <= w_idx_inc;
            r_state     <= (w_idx_inc == c_NUM_FRAMES) ? c_DONE : c_LOAD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        c_ABORT: r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Every output is decoded from registered state only.
  assign s_if.s_ready = (r_state == c_LOAD);
  assign FrameData    = r_frame_data;
  assign FrameStrobe  = (r_state == c_STROBE) ? (c_ONE << w_strobe_bit) : '0;
  assign frame_idx    = r_frame_idx;
  assign busy         = (r_state != c_IDLE);
  assign done         = (r_state == c_DONE);
  assign aborted      = (r_state == c_ABORT);

endmodule
`default_nettype wire

// File: tb/tb_frame_strobe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_strobe_sequencer
// Purpose  : Self-checking bench. Two sequencers (default parameters and a
//            FirstFrame=17 / STROBE_CYCLES=1 variant) are driven from per-cycle
//            stimulus tables; expected outputs come from a timeline model that
//            places handshakes, strobe windows and pulses arithmetically.
// Revision : 1.0  initial release
// ============================================================================
module tb_frame_strobe_sequencer;

  localparam int FB   = 32;
  localparam int MF   = 20;
  localparam int MAXC = 256;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic          sel = 1'b0;
  logic          start_drv = 1'b0;
  logic          abort_drv = 1'b0;
  logic          valid_drv = 1'b0;
  logic [FB-1:0] data_drv = '0;

  frame_strobe_sequencer_if #(.FrameBitsPerRow(FB)) if0 ();
  frame_strobe_sequencer_if #(.FrameBitsPerRow(FB)) if1 ();

  assign if0.s_valid = valid_drv & ~sel;
  assign if0.s_data  = data_drv;
  assign if1.s_valid = valid_drv & sel;
  assign if1.s_data  = data_drv;

  logic [FB-1:0] fd0, fd1;
  logic [MF-1:0] fs0, fs1;
  logic [4:0]    ix0, ix1;
  logic          b0, b1, d0, d1, a0, a1;

  frame_strobe_sequencer dut0 (
    .CLK(CLK), .reset(reset), .start(start_drv & ~sel), .abort(abort_drv & ~sel),
    .s_if(if0), .FrameData(fd0), .FrameStrobe(fs0), .frame_idx(ix0),
    .busy(b0), .done(d0), .aborted(a0)
  );

  frame_strobe_sequencer #(
    .FrameBitsPerRow(FB), .MaxFramesPerCol(MF), .NumFrames(3), .FirstFrame(17),
    .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
  ) dut1 (
    .CLK(CLK), .reset(reset), .start(start_drv & sel), .abort(abort_drv & sel),
    .s_if(if1), .FrameData(fd1), .FrameStrobe(fs1), .frame_idx(ix1),
    .busy(b1), .done(d1), .aborted(a1)
  );

  // Observed outputs of the currently selected sequencer.
  logic          o_ready, o_busy, o_done, o_abt;
  logic [FB-1:0] o_data;
  logic [MF-1:0] o_strobe;
  logic [4:0]    o_idx;
  assign o_ready  = sel ? if1.s_ready : if0.s_ready;
  assign o_busy   = sel ? b1  : b0;
  assign o_done   = sel ? d1  : d0;
  assign o_abt    = sel ? a1  : a0;
  assign o_data   = sel ? fd1 : fd0;
  assign o_strobe = sel ? fs1 : fs0;
  assign o_idx    = sel ? ix1 : ix0;

  int checks = 0;
  int errors = 0;

  // Stimulus tables, indexed by cycle of the current sequence.
  logic          v_pat  [MAXC];
  logic          a_pat  [MAXC];
  logic          st_pat [MAXC];
  logic [FB-1:0] w_pat  [MAXC];

  // Expected outputs per cycle.
  logic          e_ready  [MAXC];
  logic          e_busy   [MAXC];
  logic          e_done   [MAXC];
  logic          e_abt    [MAXC];
  logic [MF-1:0] e_strobe [MAXC];
  logic [FB-1:0] e_data   [MAXC];
  logic [4:0]    e_idx    [MAXC];
  int            e_end;

  int S, ST, H, FIRST, NF;
  logic [FB-1:0] prev_data [2];
  logic [4:0]    prev_idx  [2];

  task automatic set_dut(input int which);
    sel = (which != 0);
    S = 1; H = 1; NF = 3;
    if (which == 0) begin ST = 2; FIRST = 0;  end
    else            begin ST = 1; FIRST = 17; end
  endtask

  task automatic clear_pats();
    for (int c = 0; c < MAXC; c++) begin
      v_pat[c]  = 1'b0;
      a_pat[c]  = 1'b0;
      st_pat[c] = 1'b0;
      w_pat[c]  = $urandom;
    end
  endtask

  // Timeline model: start is taken at cycle 0, so loading begins at cycle 1.
  // Each frame is accepted at the first cycle with valid (or abort) present;
  // the strobe window and the next load opportunity follow at fixed offsets.
  task automatic build_model();
    int t, h, f;
    bit ab;
    logic [MF-1:0] one;
    one = 1;
    for (int c = 0; c < MAXC; c++) begin
      e_ready[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_abt[c] = 1'b0;
      e_strobe[c] = '0;
      e_data[c]   = prev_data[sel];
      e_idx[c]    = (c == 0) ? prev_idx[sel] : 5'd0;
    end
    t = 1; f = 0; ab = 1'b0;
    while (f < NF && !ab) begin
      h = t;
      while (h < MAXC - 20 && !v_pat[h] && !a_pat[h]) h++;
      if (!v_pat[h] && !a_pat[h]) v_pat[h] = 1'b1;
      for (int c = t; c <= h; c++) e_ready[c] = 1'b1;
      if (a_pat[h]) begin
        e_abt[h+1] = 1'b1;
        e_end = h + 1;
        ab = 1'b1;
      end else begin
        for (int c = h + 1; c < MAXC; c++) e_data[c] = w_pat[h];
        for (int c = h + 1 + S; c <= h + S + ST; c++) e_strobe[c] = one << (FIRST + f);
        t = h + 1 + S + ST + H;
        f++;
        for (int c = t; c < MAXC; c++) e_idx[c] = 5'(f);
      end
    end
    if (!ab) begin
      e_done[t] = 1'b1;
      e_end = t;
    end
    for (int c = 1; c <= e_end; c++) e_busy[c] = 1'b1;
    // Later start/abort are only legal stimulus while the sequence is live.
    for (int c = e_end; c < MAXC; c++) begin
      st_pat[c] = 1'b0;
      a_pat[c]  = 1'b0;
    end
  endtask

  // Drives the tables cycle by cycle and compares every output each cycle.
  task automatic run_and_check(input string tag, input int stop_at);
    int last;
    last = (e_end + 2 < stop_at) ? e_end + 2 : stop_at;
    for (int c = 0; c <= last; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (o_ready !== e_ready[c]) begin
        errors++; $display("FAIL %s s_ready c%0d got %b exp %b", tag, c, o_ready, e_ready[c]);
      end
      checks++;
      if (o_strobe !== e_strobe[c]) begin
        errors++; $display("FAIL %s FrameStrobe c%0d got %h exp %h", tag, c, o_strobe, e_strobe[c]);
      end
      checks++;
      if (o_data !== e_data[c]) begin
        errors++; $display("FAIL %s FrameData c%0d got %h exp %h", tag, c, o_data, e_data[c]);
      end
      checks++;
      if (o_busy !== e_busy[c]) begin
        errors++; $display("FAIL %s busy c%0d got %b exp %b", tag, c, o_busy, e_busy[c]);
      end
      checks++;
      if (o_done !== e_done[c]) begin
        errors++; $display("FAIL %s done c%0d got %b exp %b", tag, c, o_done, e_done[c]);
      end
      checks++;
      if (o_abt !== e_abt[c]) begin
        errors++; $display("FAIL %s aborted c%0d got %b exp %b", tag, c, o_abt, e_abt[c]);
      end
      checks++;
      if (o_idx !== e_idx[c]) begin
        errors++; $display("FAIL %s frame_idx c%0d got %0d exp %0d", tag, c, o_idx, e_idx[c]);
      end
      start_drv = (c == 0) || st_pat[c];
      abort_drv = a_pat[c];
      valid_drv = v_pat[c];
      data_drv  = w_pat[c];
    end
    start_drv = 1'b0; abort_drv = 1'b0; valid_drv = 1'b0;
    if (last == e_end + 2) begin
      prev_data[sel] = e_data[last];
      prev_idx[sel]  = e_idx[last];
    end
  endtask

  task automatic test_reset();
    set_dut(0);
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (fs0 !== '0 || fd0 !== '0 || if0.s_ready !== 1'b0 || b0 !== 1'b0 ||
          d0 !== 1'b0 || a0 !== 1'b0 || ix0 !== 5'd0) begin
        errors++;
        $display("FAIL reset_idle c%0d got strobe=%h data=%h ready=%b busy=%b done=%b abt=%b idx=%0d exp all 0",
                 c, fs0, fd0, if0.s_ready, b0, d0, a0, ix0);
      end
      checks++;
      if (fs1 !== '0 || fd1 !== '0 || if1.s_ready !== 1'b0 || b1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_alt c%0d got strobe=%h data=%h ready=%b busy=%b exp all 0",
                 c, fs1, fd1, if1.s_ready, b1);
      end
    end
    prev_data[0] = '0; prev_data[1] = '0;
    prev_idx[0]  = '0; prev_idx[1]  = '0;
  endtask

  task automatic test_defaults();
    set_dut(0);
    clear_pats();
    for (int c = 1; c < MAXC; c++) v_pat[c] = 1'b1;
    build_model();
    run_and_check("defaults", MAXC);
  endtask

  task automatic test_stall();
    set_dut(0);
    clear_pats();
    for (int c = 1; c < MAXC; c++) v_pat[c] = 1'b1;
    for (int c = 6; c < 10; c++) v_pat[c] = 1'b0;
    build_model();
    run_and_check("stall", MAXC);
  endtask

  task automatic test_abort();
    set_dut(0);
    clear_pats();
    for (int c = 1; c < MAXC; c++) v_pat[c] = 1'b1;
    v_pat[6] = 1'b0;
    a_pat[6] = 1'b1;
    a_pat[3] = 1'b1;   // outside LOAD: must be ignored
    build_model();
    run_and_check("abort", MAXC);
  endtask

  task automatic test_random();
    set_dut(0);
    for (int r = 0; r < 6; r++) begin
      clear_pats();
      for (int c = 0; c < MAXC; c++) begin
        v_pat[c] = ($urandom_range(0, 1) == 1);
        a_pat[c] = ($urandom_range(0, 29) == 0);
      end
      build_model();
      run_and_check("random", MAXC);
    end
  endtask

  task automatic test_reset_mid_strobe();
    set_dut(0);
    clear_pats();
    for (int c = 1; c < MAXC; c++) v_pat[c] = 1'b1;
    build_model();
    run_and_check("mid_strobe", 8);
    checks++;
    if (fs0 !== 20'h00002) begin
      errors++; $display("FAIL mid_strobe pre-reset strobe got %h exp %h", fs0, 20'h00002);
    end
    reset = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (fs0 !== '0 || fd0 !== '0 || b0 !== 1'b0 || ix0 !== 5'd0 || if0.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_strobe reset got strobe=%h data=%h busy=%b idx=%0d ready=%b exp all 0",
               fs0, fd0, b0, ix0, if0.s_ready);
    end
    reset = 1'b0;
    prev_data[0] = '0; prev_data[1] = '0;
    prev_idx[0]  = '0; prev_idx[1]  = '0;
  endtask

  task automatic test_alt_params();
    set_dut(1);
    for (int r = 0; r < 3; r++) begin
      clear_pats();
      for (int c = 0; c < MAXC; c++) begin
        v_pat[c]  = ($urandom_range(0, 2) != 0);
        st_pat[c] = ($urandom_range(0, 2) == 0);
      end
      build_model();
      run_and_check("alt_params", MAXC);
    end
    set_dut(0);
  endtask

  task automatic test_back_to_back();
    set_dut(0);
    for (int r = 0; r < 2; r++) begin
      clear_pats();
      for (int c = 1; c < MAXC; c++) v_pat[c] = 1'b1;
      build_model();
      run_and_check("back_to_back", MAXC);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_stall();
    test_abort();
    test_random();
    test_reset_mid_strobe();
    test_alt_params();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
